// File: rtl/lcd1602_ctrl.sv
// rtl/lcd1602_ctrl.sv - write-only HD44780/LCD1602 init and fixed two-line banner writer
// Ports: clk (50 MHz), rst (sync, active-high), lcd_rs (0 cmd / 1 char), lcd_rw (tied 0),
//        lcd_en (strobe, LCD latches on falling edge), lcd_data (DB7..DB0)
// Option: LCD_REFRESH_EN - after the last character, loop back to the 0x80 address command forever
module lcd1602_ctrl #(
    parameter int POWERUP_CYCLES    = 1_000_000,
    parameter int SLOT_CYCLES       = 50_000,
    parameter int CLEAR_SLOT_CYCLES = 100_000,
    parameter int SETUP_CYCLES      = 10,
    parameter int EN_WIDTH_CYCLES   = 25
) (
    input  logic       clk,
    input  logic       rst,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int MAX_A = (POWERUP_CYCLES > SLOT_CYCLES) ? POWERUP_CYCLES : SLOT_CYCLES;
    localparam int MAX_B = (MAX_A > CLEAR_SLOT_CYCLES) ? MAX_A : CLEAR_SLOT_CYCLES;
    localparam int MAX_C = (MAX_B > SETUP_CYCLES + EN_WIDTH_CYCLES) ? MAX_B
                                                                   : SETUP_CYCLES + EN_WIDTH_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_SLOT_CYCLES - 1);
    localparam logic [CW-1:0] EN_ON     = CW'(SETUP_CYCLES);
    localparam logic [CW-1:0] EN_OFF    = CW'(SETUP_CYCLES + EN_WIDTH_CYCLES);

    localparam logic [5:0] CLEAR_IDX = 6'd3;
    localparam logic [5:0] TEXT_IDX  = 6'd4;
    localparam logic [5:0] LAST_IDX  = 6'd37;

    localparam logic [127:0] LINE1 = "  SNAKE  GAME   ";
    localparam logic [127:0] LINE2 = "  DE2-115 FPGA  ";

    typedef enum logic [1:0] {POWERUP, SLOT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    idx;
    logic [CW-1:0] slot_last;

    // {rs, data} for a sequence index; leftmost string character goes out first
    function automatic logic [8:0] byte_for(input logic [5:0] i);
        int off;
        off = 0;
        if (i <= 6'd20 && i >= 6'd5) begin
            off = 8 * (20 - int'(i));
            byte_for = {1'b1, LINE1[off +: 8]};
        end else if (i >= 6'd22) begin
            off = 8 * (37 - int'(i));
            byte_for = {1'b1, LINE2[off +: 8]};
        end else begin
            case (i)
                6'd0:    byte_for = {1'b0, 8'h38};
                6'd1:    byte_for = {1'b0, 8'h0C};
                6'd2:    byte_for = {1'b0, 8'h06};
                6'd3:    byte_for = {1'b0, 8'h01};
                6'd4:    byte_for = {1'b0, 8'h80};
                default: byte_for = {1'b0, 8'hC0};
            endcase
        end
    endfunction

    // lcd_en is registered, so it is computed from the slot count the next cycle will hold
    function automatic logic strobe_at(input logic [CW-1:0] s);
        strobe_at = (s >= EN_ON) && (s < EN_OFF);
    endfunction

    always_comb begin
        slot_last = (idx == CLEAR_IDX) ? CLR_LAST : SLOT_LAST;
    end

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= POWERUP;
            cnt      <= '0;
            idx      <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (state)
                POWERUP: begin
                    if (cnt == PWR_LAST) begin
                        state              <= SLOT;
                        cnt                <= '0;
                        idx                <= '0;
                        {lcd_rs, lcd_data} <= byte_for(6'd0);
                        lcd_en             <= strobe_at('0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SLOT: begin
                    if (cnt == slot_last) begin
                        if (idx == LAST_IDX) begin
`ifdef LCD_REFRESH_EN
                            idx                <= TEXT_IDX;
                            cnt                <= '0;
                            {lcd_rs, lcd_data} <= byte_for(TEXT_IDX);
                            lcd_en             <= strobe_at('0);
`else
                            state  <= DONE;
                            lcd_en <= 1'b0;
`endif
                        end else begin
                            idx                <= idx + 6'd1;
                            cnt                <= '0;
                            {lcd_rs, lcd_data} <= byte_for(idx + 6'd1);
                            lcd_en             <= strobe_at('0);
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        lcd_en <= strobe_at(cnt + 1'b1);
                    end
                end
                DONE: begin
                    lcd_en <= 1'b0;
                end
                default: begin
                    state  <= POWERUP;
                    lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// tb/tb_lcd1602_ctrl.sv - directed self-checking bench for lcd1602_ctrl
module tb_lcd1602_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rw_bad = 0;

    localparam int PWR   = 100;
    localparam int SLOT  = 64;
    localparam int CLR   = 128;
    localparam int SETUP = 10;
    localparam int ENW   = 25;

    logic [7:0] exp_b [0:37] = '{
        8'h38, 8'h0C, 8'h06, 8'h01, 8'h80,
        8'h20, 8'h20, 8'h53, 8'h4E, 8'h41, 8'h4B, 8'h45, 8'h20,
        8'h20, 8'h47, 8'h41, 8'h4D, 8'h45, 8'h20, 8'h20, 8'h20,
        8'hC0,
        8'h20, 8'h20, 8'h44, 8'h45, 8'h32, 8'h2D, 8'h31, 8'h31,
        8'h35, 8'h20, 8'h46, 8'h50, 8'h47, 8'h41, 8'h20, 8'h20
    };

    lcd1602_ctrl #(
        .POWERUP_CYCLES   (PWR),
        .SLOT_CYCLES      (SLOT),
        .CLEAR_SLOT_CYCLES(CLR),
        .SETUP_CYCLES     (SETUP),
        .EN_WIDTH_CYCLES  (ENW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for one lcd_en pulse; returns latched byte, rise/fall cycle and stability flag
    task automatic capture(output logic [7:0] d, output logic r, output int rise_c,
                           output int fall_c, output bit stable, output bit found);
        d = 8'h00; r = 1'b0; rise_c = 0; fall_c = 0; stable = 1'b1; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad++;
            if (lcd_en === 1'b1) begin
                found = 1'b1; rise_c = cyc; d = lcd_data; r = lcd_rs;
            end
        end
        if (!found) return;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad++;
            if (lcd_data !== d || lcd_rs !== r) stable = 1'b0;
            if (lcd_en !== 1'b1) begin
                found = 1'b1; fall_c = cyc;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       r;
        int         rise_c, fall_c, prev_fall, base, bad;
        bit         stable, found;

        // reset state
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_en", {31'b0, lcd_en}, 32'd0);
        check("reset_rs", {31'b0, lcd_rs}, 32'd0);
        check("reset_data", {24'b0, lcd_data}, 32'd0);
        check("reset_rw", {31'b0, lcd_rw}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = cyc;

        // power-up quiet window: cycles 0..PWR-1
        bad = 0;
        for (int i = 0; i < PWR; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00 || lcd_rw !== 1'b0) bad++;
        end
        check("powerup_quiet", bad, 0);

        // full pass of 38 bytes
        prev_fall = 0;
        for (int i = 0; i < 38; i++) begin
            capture(d, r, rise_c, fall_c, stable, found);
            check($sformatf("byte%0d_found", i), {31'b0, found}, 32'd1);
            check($sformatf("byte%0d_data", i), {24'b0, d}, {24'b0, exp_b[i]});
            check($sformatf("byte%0d_rs", i), {31'b0, r},
                  (i <= 4 || i == 21) ? 32'd0 : 32'd1);
            check($sformatf("byte%0d_en_width", i), fall_c - rise_c, ENW);
            check($sformatf("byte%0d_stable", i), {31'b0, stable}, 32'd1);
            if (i == 0)
                check("first_rise_cycle", rise_c - base, PWR + SETUP);
            else
                check($sformatf("byte%0d_spacing", i), fall_c - prev_fall,
                      (i == 4) ? CLR : SLOT);
            prev_fall = fall_c;
        end
        check("rw_low", rw_bad, 0);

`ifdef LCD_REFRESH_EN
        capture(d, r, rise_c, fall_c, stable, found);
        check("refresh_addr_data", {24'b0, d}, 32'h80);
        check("refresh_addr_rs", {31'b0, r}, 32'd0);
        check("refresh_addr_spacing", fall_c - prev_fall, SLOT);
        capture(d, r, rise_c, fall_c, stable, found);
        check("refresh_char0_data", {24'b0, d}, 32'h20);
        check("refresh_char0_rs", {31'b0, r}, 32'd1);
`else
        bad = 0;
        for (int i = 0; i < 10 * SLOT; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0) bad++;
        end
        check("done_no_strobe", bad, 0);
        check("done_hold_data", {24'b0, lcd_data}, 32'h20);
        check("done_hold_rs", {31'b0, lcd_rs}, 32'd1);
`endif

        // restart, then reset in the middle of byte 10's strobe
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) capture(d, r, rise_c, fall_c, stable, found);
        check("pre_midreset_byte9", {24'b0, d}, {24'b0, exp_b[9]});
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) found = 1'b1;
        end
        check("byte10_strobe_seen", {31'b0, found}, 32'd1);
        check("byte10_data", {24'b0, lcd_data}, {24'b0, exp_b[10]});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_en", {31'b0, lcd_en}, 32'd0);
        check("midreset_data", {24'b0, lcd_data}, 32'd0);
        check("midreset_rs", {31'b0, lcd_rs}, 32'd0);
        rst = 1'b0;
        base = cyc;
        capture(d, r, rise_c, fall_c, stable, found);
        check("restart_found", {31'b0, found}, 32'd1);
        check("restart_rise_cycle", rise_c - base, PWR + SETUP);
        check("restart_data", {24'b0, d}, 32'h38);
        check("restart_rs", {31'b0, r}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
